// File: rtl/lane_loopback_pkg.sv
// ============================================================================
// Module  : lane_loopback_pkg
// Brief   : Shared types, range limits and data rule for lane_loopback_checker.
// Revision: 1.0
// ============================================================================
`default_nettype none

package lane_loopback_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int LANES_MIN       = 1;
    localparam int LANES_MAX       = 16;
    localparam int WIDTH_MIN       = 8;
    localparam int WIDTH_MAX       = 64;
    localparam int LATENCY_MAX     = 8;
    localparam int NUM_VECTORS_MIN = 1;
    localparam int NUM_VECTORS_MAX = 65535;

    // Full 64-bit value; callers truncate to their lane width (mod 2^WIDTH).
    function automatic logic [63:0] expected_word(input logic [15:0] v,
                                                  input int unsigned lane,
                                                  input int unsigned lanes);
        return 64'(v) * 64'(lanes) + 64'(lane) + 64'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/passthrough_pipe.sv
// ============================================================================
// Module  : passthrough_pipe
// Brief   : Data/valid shift register of LATENCY stages; LATENCY=0 is a wire.
// Revision: 1.0
// ============================================================================
`default_nettype none

module passthrough_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    if (LATENCY == 0) begin : g_comb
        assign o_valid = i_valid;
        assign o_data  = i_data;
    end else begin : g_regs
        logic [LATENCY-1:0] r_valid;
        logic [WIDTH-1:0]   r_data [LATENCY];

        always_ff @(posedge clock) begin
            if (!reset) begin
                r_valid <= '0;
            end else begin
                r_valid[0] <= i_valid;
                for (int k = 1; k < LATENCY; k++) begin
                    r_valid[k] <= r_valid[k-1];
                end
            end
        end

        // Data needs no reset: it is only observed alongside its valid bit.
        always_ff @(posedge clock) begin
            r_data[0] <= i_data;
            for (int k = 1; k < LATENCY; k++) begin
                r_data[k] <= r_data[k-1];
            end
        end

        assign o_valid = r_valid[LATENCY-1];
        assign o_data  = r_data[LATENCY-1];
    end

endmodule

`default_nettype wire

// File: rtl/lane_loopback_checker.sv
// ============================================================================
// Module  : lane_loopback_checker
// Brief   : Multi-lane numbered-vector loopback self-checker.
//           Optional first-fail capture: LANE_LOOPBACK_FIRST_FAIL_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lane_loopback_checker
    import lane_loopback_pkg::*;
#(
    parameter int LANES       = 3,
    parameter int WIDTH       = 32,
    parameter int LATENCY     = 2,
    parameter int NUM_VECTORS = 16,
    parameter int ERR_W       = 16,
    localparam int FAIL_LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             inject_err,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [15:0]      vec_issued
`ifdef LANE_LOOPBACK_FIRST_FAIL_EN
    ,
    output logic                   fail_valid,
    output logic [FAIL_LANE_W-1:0] fail_lane,
    output logic [15:0]            fail_vec
`endif
);

    localparam int  CNT_W = $clog2(LANES + 1);
    localparam int  SUM_W = ERR_W + CNT_W + 1;
    localparam bit  PARAMS_OK = (LANES >= LANES_MIN) && (LANES <= LANES_MAX) &&
                                (WIDTH >= WIDTH_MIN) && (WIDTH <= WIDTH_MAX) &&
                                (LATENCY >= 0) && (LATENCY <= LATENCY_MAX) &&
                                (NUM_VECTORS >= NUM_VECTORS_MIN) &&
                                (NUM_VECTORS <= NUM_VECTORS_MAX) && (ERR_W >= 1);
    localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS - 1);

    state_t             r_state;
    logic [15:0]        r_tx_vec;
    logic [15:0]        r_rx_vec;
    logic [ERR_W-1:0]   r_err_count;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;

    logic [LANES-1:0]   w_lane_valid;
    logic [LANES-1:0]   w_mismatch;
    logic [CNT_W-1:0]   w_mis_cnt;
    logic [SUM_W-1:0]   w_err_sum;
    logic [ERR_W-1:0]   w_err_next;
    logic               w_issue;
    logic               w_rx_fire;
    logic               w_start_run;
    logic               w_last_issue;
    logic               w_finish;

    assign w_issue      = (r_state == RUN);
    assign w_rx_fire    = |w_lane_valid;
    // A misconfigured instance never leaves IDLE rather than running garbage.
    assign w_start_run  = PARAMS_OK && start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last_issue = w_issue && (r_tx_vec == LAST_VEC);
    assign w_finish     = w_rx_fire && (r_rx_vec == LAST_VEC) &&
                          ((r_state == RUN) || (r_state == DRAIN));

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [WIDTH-1:0] w_tx_word;
        logic [WIDTH-1:0] w_rx_word;
        logic [WIDTH-1:0] w_exp_word;
        logic             w_rx_valid;

        assign w_tx_word  = WIDTH'(expected_word(r_tx_vec, gi, LANES)) ^
                            WIDTH'((gi == 0) && inject_err && w_issue);
        assign w_exp_word = WIDTH'(expected_word(r_rx_vec, gi, LANES));

        passthrough_pipe #(
            .WIDTH   (WIDTH),
            .LATENCY (LATENCY)
        ) u_pipe (
            .clock   (clock),
            .reset   (reset),
            .i_valid (w_issue),
            .i_data  (w_tx_word),
            .o_valid (w_rx_valid),
            .o_data  (w_rx_word)
        );

        assign w_lane_valid[gi] = w_rx_valid;
        assign w_mismatch[gi]   = w_rx_valid && (w_rx_word != w_exp_word);
    end

    always_comb begin
        w_mis_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            w_mis_cnt = w_mis_cnt + CNT_W'(w_mismatch[i]);
        end
    end

    assign w_err_sum  = SUM_W'(r_err_count) + SUM_W'(w_mis_cnt);
    assign w_err_next = (w_err_sum[SUM_W-1:ERR_W] != '0) ? {ERR_W{1'b1}}
                                                         : w_err_sum[ERR_W-1:0];

`ifdef LANE_LOOPBACK_FIRST_FAIL_EN
    logic                   r_fail_valid;
    logic [FAIL_LANE_W-1:0] r_fail_lane;
    logic [15:0]            r_fail_vec;
    logic [FAIL_LANE_W-1:0] w_first_lane;

    always_comb begin
        w_first_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (w_mismatch[i]) w_first_lane = FAIL_LANE_W'(i);
        end
    end

    assign fail_valid = r_fail_valid;
    assign fail_lane  = r_fail_lane;
    assign fail_vec   = r_fail_vec;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_tx_vec    <= '0;
            r_rx_vec    <= '0;
            r_err_count <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
`ifdef LANE_LOOPBACK_FIRST_FAIL_EN
            r_fail_valid <= 1'b0;
            r_fail_lane  <= '0;
            r_fail_vec   <= '0;
`endif
        end else begin
            if (w_rx_fire) r_rx_vec <= r_rx_vec + 16'd1;
            r_err_count <= w_err_next;
`ifdef LANE_LOOPBACK_FIRST_FAIL_EN
            if (!r_fail_valid && (|w_mismatch)) begin
                r_fail_valid <= 1'b1;
                r_fail_lane  <= w_first_lane;
                r_fail_vec   <= r_rx_vec;
            end
`endif
            case (r_state)
                RUN: begin
                    r_tx_vec <= r_tx_vec + 16'd1;
                    if (w_last_issue) r_state <= DRAIN;
                end
                default: ;
            endcase

            // With LATENCY=0 the last word returns in its issue cycle, skipping DRAIN.
            if (w_finish) begin
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_pass  <= (w_err_next == '0);
            end

            if (w_start_run) begin
                r_state     <= RUN;
                r_tx_vec    <= '0;
                r_rx_vec    <= '0;
                r_err_count <= '0;
                r_busy      <= 1'b1;
                r_done      <= 1'b0;
                r_pass      <= 1'b0;
`ifdef LANE_LOOPBACK_FIRST_FAIL_EN
                r_fail_valid <= 1'b0;
                r_fail_lane  <= '0;
                r_fail_vec   <= '0;
`endif
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err_count;
    assign vec_issued = r_tx_vec;

endmodule

`default_nettype wire
